// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register and its upstream sequencer.
package usr_pkg;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/usr_shift_ctrl.sv
// Sequencer that loads a command word into the attached USR and shifts it out
// one bit per accepted serial beat, MSB-first or LSB-first.
module usr_shift_ctrl
  import usr_pkg::*;
#(
  parameter int unsigned SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [SIZE-1:0] cmd_data,
  input  logic            cmd_dir,
  input  logic            cmd_fill,
  output logic [1:0]      usr_select,
  output logic [SIZE-1:0] usr_parallelin,
  output logic            usr_left,
  output logic            usr_right,
  input  logic [SIZE-1:0] usr_q,
  output logic            ser_valid,
  input  logic            ser_ready,
  output logic            ser_data,
  output logic            done
);

  localparam int unsigned CNT_W = $clog2(SIZE + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SIZE-1:0]   data_q, data_d;
  logic              dir_q, dir_d;
  logic              fill_q, fill_d;

  // Only the two end bits of the USR are read; the rest is intentionally ignored.
  logic unused_usr_q;
  assign unused_usr_q = ^usr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
    end
  end

  assign usr_left  = fill_q;
  assign usr_right = fill_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    data_d         = data_q;
    dir_d          = dir_q;
    fill_d         = fill_q;
    cmd_ready      = 1'b0;
    usr_select     = SEL_HOLD;
    usr_parallelin = '0;
    ser_valid      = 1'b0;
    ser_data       = 1'b0;
    done           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          data_d  = cmd_data;
          dir_d   = cmd_dir;
          fill_d  = cmd_fill;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        usr_select     = SEL_LOAD;
        usr_parallelin = data_q;
        cnt_d          = '0;
        state_d        = ST_SHIFT;
      end
      ST_SHIFT: begin
        ser_valid = 1'b1;
        ser_data  = dir_q ? usr_q[0] : usr_q[SIZE-1];
        // Stalled beats hold the USR so ser_data stays put under backpressure.
        if (ser_ready) begin
          usr_select = dir_q ? SEL_RIGHT : SEL_LEFT;
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SIZE - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Directed bench for usr_shift_ctrl driving a behavioural 4-bit universal shift register.
module tb_usr_shift_ctrl;
  import usr_pkg::*;

  localparam int unsigned SIZE = 4;

  logic            clk;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [SIZE-1:0] cmd_data;
  logic            cmd_dir;
  logic            cmd_fill;
  logic [1:0]      usr_select;
  logic [SIZE-1:0] usr_parallelin;
  logic            usr_left;
  logic            usr_right;
  logic [SIZE-1:0] usr_q;
  logic            ser_valid;
  logic            ser_ready;
  logic            ser_data;
  logic            done;

  int total;
  int bad;

  usr_shift_ctrl #(.SIZE(SIZE)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_data       (cmd_data),
    .cmd_dir        (cmd_dir),
    .cmd_fill       (cmd_fill),
    .usr_select     (usr_select),
    .usr_parallelin (usr_parallelin),
    .usr_left       (usr_left),
    .usr_right      (usr_right),
    .usr_q          (usr_q),
    .ser_valid      (ser_valid),
    .ser_ready      (ser_ready),
    .ser_data       (ser_data),
    .done           (done)
  );

  // Attached USR: 11 load, 10 toward MSB with left in, 01 toward LSB with right in.
  always @(posedge clk) begin
    if (rst) usr_q <= '0;
    else begin
      case (usr_select)
        2'b11:   usr_q <= usr_parallelin;
        2'b10:   usr_q <= {usr_q[SIZE-2:0], usr_left};
        2'b01:   usr_q <= {usr_right, usr_q[SIZE-1:1]};
        default: usr_q <= usr_q;
      endcase
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one word from IDLE; stall bit i drops ser_ready on SHIFT cycle i.
  // exp_bits[SIZE-1] is the first bit expected on the link.
  task automatic run_word(input logic [3:0] w, input logic d, input logic f,
                          input logic [15:0] stall, input logic [3:0] exp_bits,
                          input logic [3:0] exp_q, input int exp_cycles);
    int beats;
    int cyc;
    cmd_valid = 1'b1;
    cmd_data  = w;
    cmd_dir   = d;
    cmd_fill  = f;
    ser_ready = 1'b0;
    #1;
    check("accept_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_data  = 4'hF;
    check("load_sel", 32'(usr_select), 32'(SEL_LOAD));
    check("load_pin", 32'(usr_parallelin), 32'(w));
    check("load_vld", 32'(ser_valid), 32'd0);
    check("load_rdy", 32'(cmd_ready), 32'd0);
    tick();
    beats = 0;
    cyc   = 0;
    while (beats < 4 && cyc < 20) begin
      ser_ready = ~stall[cyc];
      #1;
      check("shift_vld", 32'(ser_valid), 32'd1);
      check("shift_bit", 32'(ser_data), 32'(exp_bits[3-beats]));
      if (ser_ready) begin
        check("shift_sel", 32'(usr_select), d ? 32'(SEL_RIGHT) : 32'(SEL_LEFT));
        beats++;
      end else begin
        check("stall_sel", 32'(usr_select), 32'(SEL_HOLD));
      end
      tick();
      cyc++;
    end
    ser_ready = 1'b0;
    #1;
    check("shift_cycles", 32'(cyc), 32'(exp_cycles));
    check("done_pulse", 32'(done), 32'd1);
    check("done_vld", 32'(ser_valid), 32'd0);
    check("done_sel", 32'(usr_select), 32'(SEL_HOLD));
    check("done_q", 32'(usr_q), 32'(exp_q));
    tick();
    check("post_done", 32'(done), 32'd0);
    check("post_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int acc1;
    int acc2;
    int cyc;
    logic [7:0] stream;
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    cmd_dir   = 1'b0;
    cmd_fill  = 1'b0;
    ser_ready = 1'b0;

    // Reset then idle.
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_sel", 32'(usr_select), 32'd0);
      check("rst_vld", 32'(ser_valid), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_q", 32'(usr_q), 32'd0);
    end

    // MSB first, fill 0.
    run_word(4'b1011, 1'b0, 1'b0, 16'h0000, 4'b1011, 4'b0000, 4);
    // LSB first, fill 1.
    run_word(4'b1011, 1'b1, 1'b1, 16'h0000, 4'b1101, 4'b1111, 4);
    // Backpressure on 2nd and 3rd SHIFT cycles.
    run_word(4'b0110, 1'b0, 1'b0, 16'h0006, 4'b0110, 4'b0000, 6);

    // Back-to-back with cmd_valid held high.
    acc1 = -1;
    acc2 = -1;
    stream = '0;
    cmd_valid = 1'b1;
    cmd_data  = 4'b0101;
    cmd_dir   = 1'b0;
    cmd_fill  = 1'b0;
    ser_ready = 1'b1;
    cyc = 0;
    while (acc2 < 0 && cyc < 40) begin
      #1;
      if (ser_valid && ser_ready) stream = {stream[6:0], ser_data};
      if (cmd_valid && cmd_ready) begin
        if (acc1 < 0) acc1 = cyc;
        else acc2 = cyc;
      end
      tick();
      if (acc1 >= 0) cmd_data = 4'b1100;
      cyc++;
    end
    cmd_valid = 1'b0;
    check("b2b_gap", 32'(acc2 - acc1), 32'd7);
    for (int i = 0; i < 6; i++) begin
      #1;
      if (ser_valid && ser_ready) stream = {stream[6:0], ser_data};
      tick();
    end
    check("b2b_stream", 32'(stream), 32'h5C);
    check("b2b_idle", 32'(cmd_ready), 32'd1);
    ser_ready = 1'b0;

    // Reset during the 2nd SHIFT beat.
    cmd_valid = 1'b1;
    cmd_data  = 4'b1011;
    ser_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("abort_in_shift", 32'(ser_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ser_ready = 1'b0;
    #1;
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_vld", 32'(ser_valid), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q", 32'(usr_q), 32'd0);
    tick();
    check("abort_nodone", 32'(done), 32'd0);
    run_word(4'b1011, 1'b0, 1'b0, 16'h0000, 4'b1011, 4'b0000, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
